// File: rtl/alu_exec_ctrl_if.sv
// rtl/alu_exec_ctrl_if.sv - instruction handshake and ALU operand/result bus for alu_exec_ctrl
interface alu_exec_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_instr;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic [3:0] alu_nzcv;

    modport master (
        output in_valid, in_instr, alu_result, alu_nzcv,
        input  in_ready, alu_a, alu_b, alu_op
    );

    modport slave (
        input  in_valid, in_instr, alu_result, alu_nzcv,
        output in_ready, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - execute-stage controller: 4x8 register file, registered ALU operands, NZCV writeback
module alu_exec_ctrl #(
    parameter int ALU_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_exec_ctrl_if.slave       bus,
    input  logic                 ld_en,
    input  logic [1:0]           ld_addr,
    input  logic [7:0]           ld_data,
    input  logic [1:0]           rd_addr,
    output logic [7:0]           rd_data,
    output logic [3:0]           flags,
    output logic                 done
);

    localparam int CW = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_WAIT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    wb_rd;
    logic          wb_nowb;
    logic [7:0]    regs [4];
    logic          wb_write;

    assign bus.in_ready = (state == ST_IDLE);
    assign done         = (state == ST_WB);
    assign wb_write     = (state == ST_WB) && !wb_nowb;
    assign rd_data      = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            wb_rd      <= 2'd0;
            wb_nowb    <= 1'b0;
            bus.alu_a  <= 8'h00;
            bus.alu_b  <= 8'h00;
            bus.alu_op <= 3'b000;
            flags      <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        wb_rd      <= bus.in_instr[4:3];
                        wb_nowb    <= bus.in_instr[0];
                        bus.alu_a  <= regs[bus.in_instr[4:3]];
                        bus.alu_b  <= regs[bus.in_instr[2:1]];
                        bus.alu_op <= bus.in_instr[7:5];
                        wait_cnt   <= '0;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= '0;
                        state    <= ST_WB;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                ST_WB: begin
                    flags <= bus.alu_nzcv;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // A writeback to the same register takes precedence over a direct load.
            if (ld_en && !(wb_write && (ld_addr == wb_rd))) begin
                regs[ld_addr] <= ld_data;
            end
            if (wb_write) begin
                regs[wb_rd] <= bus.alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - self-checking bench for alu_exec_ctrl with a behavioural ALU stub
module tb_alu_exec_ctrl;

    localparam int W = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] flags;
    logic       done;

    alu_exec_ctrl_if bus ();

    alu_exec_ctrl #(.ALU_WAIT(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .flags   (flags),
        .done    (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_regs [4];
    logic [3:0] m_flags;

    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
            default: begin r = {1'b0, a[7:1]}; c = a[0]; end
        endcase
        return {r, r[7], (r == 8'h00), c, v};
    endfunction

    always_comb begin
        {bus.alu_result, bus.alu_nzcv} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic check_regs();
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            rd(2'(i), v);
            chk($sformatf("reg%0d", i), v, m_regs[i]);
        end
    endtask

    task automatic ld(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done && c < 20) begin
            tick();
            c++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic run_instr(input logic [7:0] instr, input bit mid_ld, input logic [1:0] la, input logic [7:0] lv);
        logic [7:0]  ea, eb;
        logic [11:0] r;
        int cyc;
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("accept_ready", bus.in_ready, 1);
        ea = m_regs[instr[4:3]];
        eb = m_regs[instr[2:1]];
        tick();
        bus.in_valid = 1'b0;
        chk("op_a", bus.alu_a, ea);
        chk("op_b", bus.alu_b, eb);
        chk("op_code", bus.alu_op, instr[7:5]);
        chk("busy_ready", bus.in_ready, 0);
        if (mid_ld) begin
            ld_en = 1'b1; ld_addr = la; ld_data = lv;
        end
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
            if (mid_ld && cyc == 1) begin
                ld_en = 1'b0;
                m_regs[la] = lv;
            end
        end
        chk("wb_latency", cyc, W);
        chk("held_a", bus.alu_a, ea);
        chk("held_b", bus.alu_b, eb);
        chk("held_op", bus.alu_op, instr[7:5]);
        r = alu_ref(ea, eb, instr[7:5]);
        tick();
        m_flags = r[3:0];
        if (!instr[0]) m_regs[instr[4:3]] = r[11:4];
        chk("done_pulse_end", done, 0);
        chk("flags", flags, m_flags);
        check_regs();
    endtask

    typedef struct {
        logic [31:0] init;
        logic [7:0]  instr;
        logic [7:0]  exp_rd;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [7:0] v;
        logic       seen_done;

        vecs[0] = '{32'h0000_0305, 8'h02, 8'h08, 4'b0000};
        vecs[1] = '{32'h01FF_0000, 8'h17, 8'hFF, 4'b0110};
        vecs[2] = '{32'h0000_8000, 8'h0A, 8'h00, 4'b0111};
        vecs[3] = '{32'h0000_0503, 8'h22, 8'hFE, 4'b1000};
        vecs[4] = '{32'h3CF0_0000, 8'h56, 8'h30, 4'b0000};
        vecs[5] = '{32'h5A00_0000, 8'h9E, 8'h00, 4'b0100};

        rst = 1'b1; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00; rd_addr = 2'd0;
        bus.in_valid = 1'b0; bus.in_instr = 8'h00;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 4'b0000;

        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_alu_a", bus.alu_a, 8'h00);
        chk("rst_alu_b", bus.alu_b, 8'h00);
        chk("rst_alu_op", bus.alu_op, 3'b000);
        check_regs();

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) ld(2'(i), vecs[t].init[8*i +: 8]);
            run_instr(vecs[t].instr, 1'b0, 2'd0, 8'h00);
            rd(vecs[t].instr[4:3], v);
            chk($sformatf("tbl%0d_rd", t), v, vecs[t].exp_rd);
            chk($sformatf("tbl%0d_flags", t), flags, vecs[t].exp_flags);
        end

        // back-to-back: in_valid held high, second instruction reads first result
        ld(2'd0, 8'h01);
        ld(2'd1, 8'h02);
        bus.in_valid = 1'b1;
        bus.in_instr = 8'h02;
        tick();
        bus.in_instr = 8'h08;
        for (int k = 0; k <= W; k++) begin
            chk("b2b_busy", bus.in_ready, 0);
            if (k == W) chk("b2b_done", done, 1);
            tick();
        end
        chk("b2b_ready_again", bus.in_ready, 1);
        chk("b2b_done_low", done, 0);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_op_a", bus.alu_a, 8'h02);
        chk("b2b_op_b", bus.alu_b, 8'h03);
        wait_done();
        tick();
        m_regs[0] = 8'h03; m_regs[1] = 8'h05; m_flags = 4'b0000;
        check_regs();

        // load to rd during the writeback cycle loses to the result
        ld(2'd2, 8'h10);
        ld(2'd3, 8'h20);
        bus.in_valid = 1'b1; bus.in_instr = 8'h16;
        tick();
        bus.in_valid = 1'b0;
        wait_done();
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA;
        tick();
        ld_en = 1'b0;
        rd(2'd2, v);
        chk("coll_wb_wins", v, 8'h30);

        // with nowb set the same load is honoured
        bus.in_valid = 1'b1; bus.in_instr = 8'h17;
        tick();
        bus.in_valid = 1'b0;
        wait_done();
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'h55;
        tick();
        ld_en = 1'b0;
        rd(2'd2, v);
        chk("coll_nowb_load", v, 8'h55);
        chk("coll_nowb_flags", flags, 4'b0000);
        m_regs[2] = 8'h55; m_flags = 4'b0000;

        // load to rs during EXEC does not disturb alu_b
        run_instr(8'h1A, 1'b1, 2'd1, 8'hC3);

        // reset in the middle of EXEC aborts the instruction
        ld(2'd1, 8'h07);
        bus.in_valid = 1'b1; bus.in_instr = 8'h0A;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_ready", bus.in_ready, 1);
        chk("mrst_done", done, 0);
        chk("mrst_flags", flags, 4'b0000);
        chk("mrst_alu_a", bus.alu_a, 8'h00);
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_flags = 4'b0000;
        check_regs();
        seen_done = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        chk("mrst_no_done", seen_done, 0);
        rd(2'd1, v);
        chk("mrst_rd_zero", v, 8'h00);

        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) ld(2'($urandom_range(0, 3)), 8'($urandom));
            run_instr(8'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
